sram_arbiter: RTL
=================

# sram_arbiter

Shares the single 16-bit off-chip SRAM between two 32-bit requesters: port 0, the MEM-stage cache controller, and port 1, a secondary master such as a loader or DMA. Each granted 32-bit access runs as two 16-bit SRAM phases (low half, then high half) with a fixed number of wait cycles per phase. Completion is signalled per port with a one-cycle `ready` pulse. When both ports are pending, access alternates round-robin.

## Interface
- `WAIT_CYCLES`, default 2: cycles per 16-bit phase; must be ≥1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high until that port sees `ready`.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr0` / `addr1`  in  32  byte address. Only bits [18:2] are used; [1:0] and [31:19] are ignored.
- `wdata0` / `wdata1`  in  32  write data.
- `rdata0` / `rdata1`  out  32  registered read data. Reset value 0. Holds its value until the next read completes on that port.
- `ready0` / `ready1`  out  1  one-cycle completion pulse. Reset value 0.
- `SRAM_DQ`  inout  16  SRAM data bus. Driven only during write phases; high-Z otherwise.
- `SRAM_ADDR`  out  18  set to {addr[18:2], half}, where half = 0 for the low phase and 1 for the high phase. Reset value 0.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`  out  1  all low during the LO and HI states; high otherwise. Reset value 1.
- `SRAM_OE_N`  out  1  low during the LO and HI states of a read; high otherwise. Reset value 1.
- `SRAM_WE_N`  out  1  low during the LO and HI states of a write; high otherwise. Reset value 1.

## Operation
- Four states: IDLE, LO, HI, DONE. Reset forces IDLE.
- **IDLE**
  - Samples `req0` and `req1`.
  - If exactly one is high, that port is granted.
  - If both are high, the port named by the priority pointer `prio` is granted. `prio` resets to 0.
  - On a grant: latch the port id, `we`, `addr[18:2]` and `wdata`; load `cnt` = WAIT_CYCLES-1; go to LO.
  - With no request, stay in IDLE.
- **LO**
  - `SRAM_ADDR` = {word, 0}.
  - On a write, `SRAM_DQ` is driven with wdata[15:0].
  - `cnt` decrements each cycle.
  - When `cnt` = 0: a read captures `SRAM_DQ` into the low half of a holding register; reload `cnt`; go to HI.
- **HI**
  - Same as LO, except `SRAM_ADDR` = {word, 1}, writes drive wdata[31:16], and reads capture into the high half.
  - When `cnt` = 0, go to DONE.
- **DONE**
  - The granted port's `ready` is high for this cycle only.
  - On a read, that port's `rdata` is updated with the holding register at the DONE clock edge, so it is valid from the cycle after DONE.
  - `rdata` of the other port is never modified.
  - `prio` becomes the non-granted port.
  - Next state is IDLE.
- Latched address and data are used for the whole access; requester inputs may change after the IDLE sampling edge without effect.
- A requester drops or changes `req` on the edge at which it samples `ready`. The next IDLE cycle therefore sees a new request.
- `ready0` and `ready1` are never high together. `ready` is never asserted without a grant.

## Timing
- Latency, from the IDLE cycle in which the request is sampled (cycle 0) to `ready`, is 2·WAIT_CYCLES+1 cycles. With the default WAIT_CYCLES = 2:
  - cycles 1–2: LO
  - cycles 3–4: HI
  - cycle 5: DONE, `ready` high
  - cycle 6: IDLE
- Back-to-back throughput is one access per 2·WAIT_CYCLES+2 cycles.
- Under continuous `req0` and `req1`, grants strictly alternate.
- A single active port is never starved or delayed by `prio`.
- Reset low at any time, including mid-access:
  - immediate return to IDLE;
  - all SRAM_*_N outputs high and `SRAM_DQ` high-Z;
  - `ready` outputs 0, `rdata` outputs 0, `prio` 0;
  - the aborted access produces no `ready`.
- After reset release, a still-high `req` is treated as a new request.

## Test plan
- **Write:** port 0 write, addr 0x0000_0010, data 0xDEADBEEF, WAIT_CYCLES = 2 -> `SRAM_ADDR` = 0x00008 with DQ = 0xBEEF and WE_N low in cycles 1–2; then `SRAM_ADDR` = 0x00009 with DQ = 0xDEAD in cycles 3–4; `ready0` high in cycle 5 only; `ready1` stays 0.
- **Read and alias:** port 1 reads 0x0000_0010 after the write above -> OE_N low and WE_N high in cycles 1–4; `ready1` in cycle 5; `rdata1` = 0xDEADBEEF from cycle 6; `rdata0` unchanged. A read of addr 0x0008_0013 returns the same value (address alias).
- **Contention:** `req0` and `req1` both rise in the same cycle after reset -> port 0 is served with `ready0` at cycle 5; port 1 is served next with `ready1` at cycle 11. With both held continuously, grants alternate 0,1,0,1.
- **Single port:** only `req1` is asserted, repeatedly -> served every 6 cycles with no idle gaps beyond one IDLE cycle, regardless of `prio`.
- **Reset mid-access:** `rst` pulled low during HI of a port 0 write -> SRAM_*_N all high and DQ high-Z within the reset cycle; no `ready0` pulse. With `req0` still high after release, the access restarts from LO and completes 5 cycles later.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter for a 16-bit asynchronous SRAM
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        ready0,
    output logic        ready1,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prio_q;
    logic          port_q;
    logic          we_q;
    logic [16:0]   word_q;
    logic [31:0]   wdata_q;
    logic [31:0]   hold_q;

    logic          grant_valid;
    logic          grant_port;
    logic          load_grant;
    logic          cap_lo;
    logic          cap_hi;
    logic          active;
    logic          dq_oe;
    logic [15:0]   dq_out;

    // Only word-address bits [18:2] reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:19], addr0[1:0], addr1[31:19], addr1[1:0]};

    // The pointer only matters on a tie; a lone requester always wins.
    assign grant_valid = req0 | req1;
    assign grant_port  = (req0 && req1) ? prio_q : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_grant = 1'b0;
        cap_lo     = 1'b0;
        cap_hi     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    load_grant = 1'b1;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_q == '0) begin
                    cap_lo  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_HI;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HI: begin
                if (cnt_q == '0) begin
                    cap_hi  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q  <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (load_grant) begin
                port_q  <= grant_port;
                we_q    <= grant_port ? we1 : we0;
                word_q  <= grant_port ? addr1[18:2] : addr0[18:2];
                wdata_q <= grant_port ? wdata1 : wdata0;
            end
            if (cap_lo && !we_q) begin
                hold_q[15:0] <= SRAM_DQ;
            end
            if (cap_hi && !we_q) begin
                hold_q[31:16] <= SRAM_DQ;
            end
            if (state_q == ST_DONE) begin
                prio_q <= ~port_q;
                if (!we_q) begin
                    if (port_q) begin
                        rdata1 <= hold_q;
                    end else begin
                        rdata0 <= hold_q;
                    end
                end
            end
        end
    end

    // Strobes decode straight from the state register so reset releases the bus at once.
    assign active    = (state_q == ST_LO) || (state_q == ST_HI);
    assign dq_oe     = active && we_q;
    assign dq_out    = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_ADDR = {word_q, (state_q == ST_HI)};
    assign SRAM_CE_N = ~active;
    assign SRAM_UB_N = ~active;
    assign SRAM_LB_N = ~active;
    assign SRAM_OE_N = ~(active && !we_q);
    assign SRAM_WE_N = ~(active && we_q);

    assign ready0 = (state_q == ST_DONE) && !port_q;
    assign ready1 = (state_q == ST_DONE) && port_q;

endmodule
